serial_adder_ctrl: RTL

Bit-serial N-bit adder controller that time-multiplexes a single half-adder cell to produce a full ripple-carry sum. Each operand bit takes two half-adder passes: a+b first, then partial-sum+carry. A start/busy/done handshake connects it to board switch/LED glue or to a higher-level sequencer. It is the first sequential user of the half-adder datapath, trading area for 2·WIDTH+1 cycles of latency.

---
 rtl/serial_adder_ctrl_pkg.sv | 16 +
 rtl/serial_adder_ctrl_if.sv | 15 +
 rtl/serial_adder_ctrl_half_adder_cell.sv | 10 +
 rtl/serial_adder_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PH_AB  = 2'd1,
        S_PH_SC  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    // Bit-index counter width; never narrower than one bit, even for WIDTH=1.
    function automatic int idx_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses for serial_adder_ctrl.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl_half_adder_cell.sv
// Single combinational half-adder cell, time-shared by the serial adder.
module half_adder_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial ripple-carry adder: one half-adder cell, two passes per operand bit.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for start; operands captured when it is seen
// S_PH_AB  | pass 1: opa[0] + opb[0] -> s1/c1
// S_PH_SC  | pass 2: s1 + carry -> result bit, carry update, shift
// S_FINISH | done pulse; new sum/cout visible this cycle
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                CLOCK_50,
    input  logic                KEY0,
    serial_adder_ctrl_if.slave  bus
);

    localparam int                IDXW = idx_width(WIDTH);
    localparam logic [IDXW-1:0]   LAST = IDXW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             s1_q, s1_d;
    logic             c1_q, c1_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             ha_x, ha_y, ha_s, ha_c;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        ha_x = opa_q[0];
        ha_y = opb_q[0];
        if (state_q == S_PH_SC) begin
            ha_x = s1_q;
            ha_y = carry_q;
        end
    end

    half_adder_cell u_ha (
        .x (ha_x),
        .y (ha_y),
        .s (ha_s),
        .c (ha_c)
    );

    assign res_next = WIDTH'({ha_s, res_q} >> 1);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.b;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_PH_AB;
                end
            end
            S_PH_AB: begin
                s1_d    = ha_s;
                c1_d    = ha_c;
                state_d = S_PH_SC;
            end
            S_PH_SC: begin
                res_d   = res_next;
                carry_d = c1_q | ha_c;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                if (idx_q == LAST) begin
                    // Output registers load on the edge into FINISH so the new
                    // result is already visible while done is high.
                    sum_d   = res_next;
                    cout_d  = c1_q | ha_c;
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_PH_AB;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == S_PH_AB) || (state_q == S_PH_SC);
    assign bus.done = (state_q == S_FINISH);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
